// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed 7-segment display scanner.
// A shadow register holds the digit codes and decimal point requests; a
// prescaler paces a digit index that walks 0..DIGITS-1. Every output is
// registered from the current index and shadow contents, so any index change
// or shadow load reaches the pins one edge later.
module seg7_scan #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned TICKS  = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   number,
    input  logic [DIGITS-1:0]     dot_ena,
    input  logic                  load,
    input  logic                  ena,
    input  logic                  hex,
    input  logic                  lzb,
    output logic [6:0]            seg,
    output logic                  dot,
    output logic [DIGITS-1:0]     an,
    output logic                  frame
);

    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned PW = (TICKS > 1) ? $clog2(TICKS) : 1;

    localparam logic [IW-1:0] LAST_IDX  = IW'(DIGITS - 1);
    localparam logic [PW-1:0] LAST_TICK = PW'(TICKS - 1);

    // Segment patterns {a,b,c,d,e,f,g}; hex letters only when hex_en is set.
    function automatic logic [6:0] seg_decode(input logic [3:0] code, input logic hex_en);
        logic [6:0] s;
        case (code)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = hex_en ? 7'b1110111 : 7'b0000000;
            4'hB: s = hex_en ? 7'b0011111 : 7'b0000000;
            4'hC: s = hex_en ? 7'b1001110 : 7'b0000000;
            4'hD: s = hex_en ? 7'b0111101 : 7'b0000000;
            4'hE: s = hex_en ? 7'b1001111 : 7'b0000000;
            default: s = hex_en ? 7'b1000111 : 7'b0000000;
        endcase
        return s;
    endfunction

    logic [4*DIGITS-1:0] shadow_num_q, shadow_num_d;
    logic [DIGITS-1:0]   shadow_dot_q, shadow_dot_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                wrap_q, wrap_d;
    logic [6:0]          seg_q, seg_d;
    logic                dot_q, dot_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                frame_q, frame_d;

    logic                tick;
    logic [3:0]          cur_code;
    logic [DIGITS-1:0]   blank;
    logic                zero_above;

    // Shadow register capture.
    always_comb begin
        shadow_num_d = shadow_num_q;
        shadow_dot_d = shadow_dot_q;
        if (load) begin
            shadow_num_d = number;
            shadow_dot_d = dot_ena;
        end
    end

    // Prescaler and digit index; wrap_q remembers an index wrap so frame
    // lines up with the outputs that first show digit 0.
    always_comb begin
        tick    = (presc_q == LAST_TICK);
        presc_d = tick ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        if (tick) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
        wrap_d  = tick && (idx_q == LAST_IDX);
        frame_d = wrap_q;
    end

    // Leading-zero blanking mask, scanning from the most significant digit down.
    always_comb begin
        blank      = '0;
        zero_above = 1'b1;
        for (int unsigned j = 0; j < DIGITS; j++) begin
            zero_above = zero_above && (shadow_num_q[4*(DIGITS-1-j) +: 4] == 4'h0);
            blank[DIGITS-1-j] = lzb && (j != DIGITS - 1) && zero_above;
        end
    end

    // Output values for the currently selected digit.
    always_comb begin
        cur_code = shadow_num_q[4*idx_q +: 4];
        seg_d    = '0;
        dot_d    = 1'b0;
        an_d     = '0;
        if (ena) begin
            seg_d = blank[idx_q] ? 7'b0000000 : seg_decode(cur_code, hex);
            dot_d = shadow_dot_q[idx_q];
            an_d  = DIGITS'(1) << idx_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_num_q <= '0;
            shadow_dot_q <= '0;
            presc_q      <= '0;
            idx_q        <= '0;
            wrap_q       <= 1'b0;
            seg_q        <= '0;
            dot_q        <= 1'b0;
            an_q         <= '0;
            frame_q      <= 1'b0;
        end else begin
            shadow_num_q <= shadow_num_d;
            shadow_dot_q <= shadow_dot_d;
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            wrap_q       <= wrap_d;
            seg_q        <= seg_d;
            dot_q        <= dot_d;
            an_q         <= an_d;
            frame_q      <= frame_d;
        end
    end

    assign seg   = seg_q;
    assign dot   = dot_q;
    assign an    = an_q;
    assign frame = frame_q;

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter TICKS, default 1000, clock cycles each digit is held; legal range >= 1.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 number  input  4*DIGITS  digit codes; digit i = number[4i+3:4i], digit 0 least significant.
REQ-006 dot_ena  input  DIGITS  per-digit decimal point request; bit i belongs to digit i.
REQ-007 load  input  1  captures number and dot_ena into the shadow register.
REQ-008 ena  input  1  display enable; 0 blanks all outputs.
REQ-009 hex  input  1  1 = decode codes 10..15 as A..F; 0 = blank them.
REQ-010 lzb  input  1  1 = leading-zero blanking.
REQ-011 seg  output  7  segments {a,b,c,d,e,f,g} at bits 6..0; active-high; registered.
REQ-012 dot  output  1  decimal point of the selected digit; active-high; registered.
REQ-013 an  output  DIGITS  one-hot digit select; active-high; registered.
REQ-014 frame  output  1  one-cycle pulse per full scan; registered.

Function
REQ-015 The shadow register SHALL load number/dot_ena on every edge with load=1; the display SHALL use shadow contents only.
REQ-016 The prescaler SHALL count 0..TICKS-1 and wrap to 0; the wrap cycle is the tick.
REQ-017 On a tick, the digit index SHALL advance by 1, wrapping from DIGITS-1 to 0.
REQ-018 frame SHALL be 1 for exactly one cycle, on the edge after the index wraps DIGITS-1 -> 0; otherwise 0.
REQ-019 Outputs SHALL be registered from the current index and shadow; the index change or shadow load appears on outputs one edge later.
REQ-020 Latency load -> seg: 2 edges (shadow on edge 1, outputs on edge 2).
REQ-021 With ena=1, an SHALL equal 1<<index.
REQ-022 Decode 0..9: 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011.
REQ-023 Decode 10..15 with hex=1: A 1110111, b 0011111, C 1001110, d 0111101, E 1001111, F 1000111; with hex=0: 0000000.
REQ-024 With lzb=1, digit i (i>0) SHALL show seg=0000000 if digits DIGITS-1 down to i are all zero; digit 0 is never blanked; an is unaffected.
REQ-025 dot SHALL equal ena AND shadow dot_ena[index]; leading-zero blanking does not suppress dot.
REQ-026 With ena=0, seg, dot and an SHALL be 0; prescaler and index keep running, so re-enabling resumes at the current index.
REQ-027 frame SHALL be independent of ena.
REQ-028 A load on a tick edge takes effect together with the new index; no mixed old/new output in any cycle.
REQ-029 With TICKS=1, the index SHALL advance every cycle.
REQ-030 With DIGITS=1, the index is always 0 and frame pulses once every TICKS cycles.

Reset
REQ-031 On an edge with rst=1: shadow=0, prescaler=0, index=0, seg=0, dot=0, an=0, frame=0; rst overrides load and ena.
REQ-032 The first edge after reset release SHALL drive outputs for index 0.
REQ-033 Reset asserted mid-scan SHALL take effect on that edge with no trailing frame pulse.

Verification (DIGITS=4, TICKS=4)
REQ-034 Reset, load 16'h1234, ena=1, hex=0 -> an cycles 0001/0010/0100/1000, 4 cycles each; seg 0110011, 1111001, 1101101, 0110000.
REQ-035 load 16'hABCD: hex=1 -> digit0 seg 0111101, digit3 seg 1110111; hex=0 -> seg 0000000 on all digits, an still scanning.
REQ-036 lzb=1, load 16'h0050, dot_ena=4'b1000 -> digits 3,2 seg 0000000 (digit3 dot=1); digit1 1011011; digit0 1111110.
REQ-037 ena=0 for 6 cycles mid-scan -> seg/dot/an=0 on the next edge; after ena=1, an matches the free-running index.
REQ-038 Steady scan -> frame high exactly 1 cycle every 16 cycles.
REQ-039 rst pulse during digit 2 -> next edge all outputs 0; after release, digit 0 shows 1111110 (shadow=0).
